// File: rtl/hazard_detection_unit.sv
// Stall/flush controller for load-use, taken-branch and slow-data-memory hazards.
// Define HDU_STALL_COUNT_EN to add saturating stall_cycles/flush_count performance counters.
module hazard_detection_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int MAX_WAIT   = 15,
  parameter int WAIT_W     = 4
`ifdef HDU_STALL_COUNT_EN
  ,
  parameter int CNT_W      = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] if_id_rs1,
  input  logic [REG_ADDR_W-1:0] if_id_rs2,
  input  logic                  if_id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] id_ex_rd,
  input  logic                  id_ex_memread,
  input  logic                  branch_taken,
  input  logic                  dmem_req,
  input  logic                  dmem_ready,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic                  ex_mem_hold,
  output logic                  mem_timeout,
  output logic [1:0]            hdu_state
`ifdef HDU_STALL_COUNT_EN
  ,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_e;

  localparam logic [WAIT_W-1:0] MaxWait = WAIT_W'(MAX_WAIT);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                timeout_q, timeout_d;
  logic                load_use;

  // x0 is hard-wired zero, so a load targeting it never creates a real dependency.
  assign load_use = id_ex_memread && (id_ex_rd != '0) &&
                    ((id_ex_rd == if_id_rs1) || (if_id_uses_rs2 && (id_ex_rd == if_id_rs2)));

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    timeout_d    = timeout_q;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mem_hold  = 1'b0;
    case (state_q)
      RUN: begin
        if (dmem_req && !dmem_ready) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          ex_mem_hold = 1'b1;
          state_d     = MEM_WAIT;
          wait_cnt_d  = WAIT_W'(1);
        end else if (branch_taken) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (load_use) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!dmem_ready) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          ex_mem_hold = 1'b1;
          if (wait_cnt_q == MaxWait) begin
            state_d   = ERROR;
            timeout_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end else begin
          // Branch and load-use inputs were held stable while frozen, so resolve them now.
          state_d    = RUN;
          wait_cnt_d = '0;
          if (branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end
        end
      end
      ERROR: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        ex_mem_hold = 1'b1;
        timeout_d   = 1'b1;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
    if (!rst_n) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      ex_mem_hold  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign hdu_state   = state_q;
  assign mem_timeout = rst_n && timeout_q;

`ifdef HDU_STALL_COUNT_EN
  logic [CNT_W-1:0] stall_cycles_q, flush_count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (!pc_write && (stall_cycles_q != '1)) stall_cycles_q <= stall_cycles_q + CNT_W'(1);
      if (if_id_flush && (flush_count_q != '1)) flush_count_q <= flush_count_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Scoreboard bench for hazard_detection_unit: directed vectors push expectations,
// a negedge monitor pops and compares against the DUT outputs.
module tb_hazard_detection_unit;

  typedef struct packed {
    logic       pc;
    logic       ifw;
    logic       flush;
    logic       bubble;
    logic       hold;
    logic       tmo;
    logic [1:0] st;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstN;
  logic [4:0] rs1, rs2, rd;
  logic       usesRs2, memRead, branchTaken, dmemReq, dmemReady;
  logic       pcWrite, ifIdWrite, ifIdFlush, idExBubble, exMemHold, memTimeout;
  logic [1:0] hduState;
`ifdef HDU_STALL_COUNT_EN
  logic [15:0] stallCycles, flushCount;
`endif

  exp_t  expQ[$];
  string nameQ[$];
  int    testsRun = 0;
  int    testsFailed = 0;

  hazard_detection_unit dut (
    .clk(clk), .rst_n(rstN),
    .if_id_rs1(rs1), .if_id_rs2(rs2), .if_id_uses_rs2(usesRs2),
    .id_ex_rd(rd), .id_ex_memread(memRead), .branch_taken(branchTaken),
    .dmem_req(dmemReq), .dmem_ready(dmemReady),
    .pc_write(pcWrite), .if_id_write(ifIdWrite), .if_id_flush(ifIdFlush),
    .id_ex_bubble(idExBubble), .ex_mem_hold(exMemHold), .mem_timeout(memTimeout),
    .hdu_state(hduState)
`ifdef HDU_STALL_COUNT_EN
    , .stall_cycles(stallCycles), .flush_count(flushCount)
`endif
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic pc, ifw, fl, bub, hold, tmo, input logic [1:0] st);
    mk = '{pc, ifw, fl, bub, hold, tmo, st};
  endfunction

  task automatic applyStimulus(input logic rst, input logic [4:0] aRs1, aRs2, input logic aUses,
                               input logic [4:0] aRd, input logic aMr, aBr, aReq, aRdy);
    @(posedge clk);
    #1;
    rstN = rst; rs1 = aRs1; rs2 = aRs2; usesRs2 = aUses; rd = aRd;
    memRead = aMr; branchTaken = aBr; dmemReq = aReq; dmemReady = aRdy;
  endtask

  task automatic checkOutput(input string name, input exp_t e);
    expQ.push_back(e);
    nameQ.push_back(name);
  endtask

  // Monitor: outputs are valid every cycle, so pop one expectation per negedge when present.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      exp_t  e;
      exp_t  a;
      string n;
      e = expQ.pop_front();
      n = nameQ.pop_front();
      a = '{pcWrite, ifIdWrite, ifIdFlush, idExBubble, exMemHold, memTimeout, hduState};
      testsRun++;
      if (a !== e) begin
        testsFailed++;
        $display("[TB] FAIL %s: got pc/ifw/fl/bub/hold/tmo/st=%b expected %b", n, a, e);
      end
    end
  end

`ifdef HDU_STALL_COUNT_EN
  task automatic checkCounters(input string name, input logic [15:0] s, input logic [15:0] f);
    @(negedge clk);
    #1;
    testsRun++;
    if (stallCycles !== s || flushCount !== f) begin
      testsFailed++;
      $display("[TB] FAIL %s: stall_cycles=%0d flush_count=%0d expected %0d %0d",
               name, stallCycles, flushCount, s, f);
    end
  endtask
`endif

  initial begin
    exp_t rstOut, adv, lu, br, frz0, frz1, err;
    rstN = 1'b0; rs1 = '0; rs2 = '0; rd = '0; usesRs2 = 1'b0;
    memRead = 1'b0; branchTaken = 1'b0; dmemReq = 1'b0; dmemReady = 1'b0;
    rstOut = mk(0, 0, 1, 1, 0, 0, 2'd0);
    adv    = mk(1, 1, 0, 0, 0, 0, 2'd0);
    lu     = mk(0, 0, 0, 1, 0, 0, 2'd0);
    br     = mk(1, 1, 1, 1, 0, 0, 2'd0);
    frz0   = mk(0, 0, 0, 0, 1, 0, 2'd0);
    frz1   = mk(0, 0, 0, 0, 1, 0, 2'd1);
    err    = mk(0, 0, 0, 0, 1, 1, 2'd2);

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0); checkOutput("reset", rstOut);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0); checkOutput("idle", adv);

    // T1 load-use, T2 x0/rs2 gating
    applyStimulus(1, 5, 0, 0, 5, 1, 0, 0, 0); checkOutput("t1_loaduse", lu);
    applyStimulus(1, 5, 0, 0, 5, 0, 0, 0, 0); checkOutput("t1_after", adv);
    applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 0); checkOutput("t2_x0", adv);
    applyStimulus(1, 3, 7, 0, 7, 1, 0, 0, 0); checkOutput("t2_rs2_unused", adv);
    applyStimulus(1, 3, 7, 1, 7, 1, 0, 0, 0); checkOutput("t2_rs2_used", lu);
    applyStimulus(1, 6, 3, 1, 7, 1, 0, 0, 0); checkOutput("t2_no_match", adv);

    // T3 branch beats load-use
    applyStimulus(1, 5, 0, 0, 5, 1, 1, 0, 0); checkOutput("t3_branch_lu", br);
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 0); checkOutput("t3_branch", br);

    // T4 slow memory, 3 cycles low then ready
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 1); checkOutput("t4_ready_now", adv);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0); checkOutput("t4_miss", frz0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0); checkOutput("t4_wait1", frz1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0); checkOutput("t4_wait2", frz1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 1); checkOutput("t4_release", mk(1, 1, 0, 0, 0, 0, 2'd1));
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0); checkOutput("t4_run", adv);

    // Memory stall outranks a pending load-use, which resolves on release
    applyStimulus(1, 5, 0, 0, 5, 1, 0, 1, 0); checkOutput("mem_over_lu", frz0);
    applyStimulus(1, 5, 0, 0, 5, 1, 0, 1, 1); checkOutput("release_lu", mk(0, 0, 0, 1, 0, 0, 2'd1));
    applyStimulus(1, 5, 0, 0, 5, 0, 0, 0, 0); checkOutput("after_release_lu", adv);

    // Reset in the middle of MEM_WAIT
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0); checkOutput("mw_miss", frz0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0); checkOutput("mw_wait", frz1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0); checkOutput("mw_reset", mk(0, 0, 1, 1, 0, 0, 2'd1));
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0); checkOutput("mw_after_reset", frz0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 1); checkOutput("mw_release", mk(1, 1, 0, 0, 0, 0, 2'd1));
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0); checkOutput("mw_run", adv);

    // T5 timeout: 1 RUN miss cycle, 15 MEM_WAIT cycles, then ERROR
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0); checkOutput("t5_miss", frz0);
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0);
      checkOutput($sformatf("t5_wait%0d", i), frz1);
    end
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0); checkOutput("t5_error", err);
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 1, 1); checkOutput("t5_stuck", err);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0); checkOutput("t5_reset", mk(0, 0, 1, 1, 0, 0, 2'd2));
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0); checkOutput("t5_recovered", adv);

`ifdef HDU_STALL_COUNT_EN
    // T6: fresh reset, T1 then T4 gives four stall cycles and no flushes
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0); checkOutput("t6_reset", rstOut);
    applyStimulus(1, 5, 0, 0, 5, 1, 0, 0, 0); checkOutput("t6_lu", lu);
    applyStimulus(1, 5, 0, 0, 5, 0, 0, 0, 0); checkOutput("t6_lu_after", adv);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0); checkOutput("t6_miss", frz0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0); checkOutput("t6_wait1", frz1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0); checkOutput("t6_wait2", frz1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 1); checkOutput("t6_release", mk(1, 1, 0, 0, 0, 0, 2'd1));
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0); checkOutput("t6_run", adv);
    checkCounters("t6_counts", 16'd4, 16'd0);
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 0); checkOutput("t6_branch", br);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0); checkOutput("t6_idle", adv);
    checkCounters("t6_flush", 16'd4, 16'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0); checkOutput("t6_reset2", rstOut);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0); checkOutput("t6_idle2", adv);
    checkCounters("t6_cleared", 16'd0, 16'd0);
`endif

    @(negedge clk);
    #1;
    testsRun++;
    if (expQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
